seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//  Sequences one BCD/hex nibble at a time onto a shared combinational nibble-to-segment decoder.
//  Drives the active-low digit enables, with a blanking gap between digits to prevent ghosting.
//  Holds a pending display value, committed only at frame wrap (no tearing); sits between user logic and the decoder/pins.
// PARAMETERS
//  NUM_DIGITS    4      number of multiplexed digits (>=2); digit 0 = least significant
//  REFRESH_DIV   50000  clk cycles each digit is lit (SHOW slot length, >=1)
//  BLANK_CYCLES  16     clk cycles all digits are off between slots (>=1)
// PORTS
//  clk          in   1              system clock, rising edge
//  reset_n      in   1              asynchronous, active-low reset
//  load         in   1              1-cycle strobe: capture value into pending register
//  value        in   4*NUM_DIGITS   nibble k = value[4k+3:4k]
//  lz_en        in   1              1 = suppress leading zeros
//  nibble       out  4              nibble for current digit, to decoder input
//  digit_an_n   out  NUM_DIGITS     active-low digit enables (1 = off)
//  frame_start  out  1              1-cycle pulse, first SHOW cycle of digit 0
//  load_ack     out  1              1-cycle pulse when pending value becomes displayed
// BEHAVIOUR
//  - Registers: disp (displayed value), pend (pending value), pend_v, idx, slot counter, state.
//  - Reset (async assert, sync release) values:
//      state=BLANK, idx=0, cnt=0, disp=0, pend=0, pend_v=0.
//      digit_an_n=all 1, nibble=0, frame_start=0, load_ack=0.
//  - All outputs are registered and change only on clk edges.
//  - FSM, 2 states:
//      BLANK: digit_an_n=all 1; lasts BLANK_CYCLES cycles, then -> SHOW (same idx).
//      SHOW:  digit_an_n[idx]=0 (others 1) unless digit suppressed; nibble=disp[idx].
//             Lasts REFRESH_DIV cycles, then -> BLANK with idx=idx+1.
//  - Wrap and commit: idx wraps NUM_DIGITS-1 -> 0 on the SHOW->BLANK edge.
//      On that edge, if pend_v: disp<=pend, pend_v<=0, load_ack=1 for that one cycle.
//      New disp is first shown in the following digit-0 SHOW slot.
//  - Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
//  - frame_start is high exactly in cycle 1 of each digit-0 SHOW slot.
//  - load: pend<=value, pend_v<=1 on the edge where load=1.
//      A second load before commit overwrites pend (last wins); no extra ack.
//  - load on the same edge as a commit: disp<=old pend, load_ack=1, pend<=new value, pend_v stays 1.
//      The new value commits at the next wrap.
//  - Leading-zero suppression: digit k (k>0) is suppressed iff lz_en=1 and disp nibbles NUM_DIGITS-1..k are all 0.
//      Digit 0 is never suppressed.
//      Suppressed digit: anode stays 1 for the whole SHOW slot; timing is unchanged.
//      nibble still = disp[idx].
//      lz_en is sampled each cycle (combinational into the output register).
//  - nibble holds its last value during BLANK.
//  - Counters: cnt width = clog2(max(REFRESH_DIV,BLANK_CYCLES)). cnt resets to 0 on every state change.
//  - Reset mid-slot: outputs go to reset values immediately (async); scan restarts at BLANK idx=0; pending load is lost.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2; frame=24 cycles)
//  1. Release reset; no load:
//       2 BLANK cycles, then digit_an_n=1110 for 4 cycles, then 1111 for 2, then 1101.
//       frame_start at cycle 3 and cycle 27; nibble=0.
//  2. load value=16'h1234 mid-frame:
//       digits keep showing 0 until wrap; load_ack pulses on the digit-3 SHOW->BLANK edge.
//       Next frame nibble sequence is 4,3,2,1.
//  3. load 16'h00A5, then load 16'h0007 before wrap, lz_en=1:
//       single load_ack; disp=0007.
//       Anodes 1110 lit in slot 0; slots 1-3 stay 1111 with slot timing unchanged.
//  4. load asserted on the exact commit edge with value=16'hBEEF (pend held 16'h1111):
//       disp=1111, load_ack=1 that cycle.
//       BEEF committed one frame later with a second load_ack.
//  5. Assert reset_n=0 during digit-2 SHOW with pending load:
//       digit_an_n=1111 and nibble=0 asynchronously.
//       After release, idx restarts at 0, no load_ack, disp=0.
//  6. lz_en=1, disp=16'h0000:
//       only digit 0 lit, showing 0.
//       Toggle lz_en=0 -> all four digits light in the following slots.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bundle of user-side and pin-side signals of the 7-segment scan controller.
// The master side (user logic / bench) supplies the display value and
// options; the slave side (scan controller) drives the decoder nibble,
// the digit enables and the status pulses.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    lz_en;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   digit_an_n;
  logic                    frame_start;
  logic                    load_ack;

  modport master (
    output load,
    output value,
    output lz_en,
    input  nibble,
    input  digit_an_n,
    input  frame_start,
    input  load_ack
  );

  modport slave (
    input  load,
    input  value,
    input  lz_en,
    output nibble,
    output digit_an_n,
    output frame_start,
    output load_ack
  );

endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Each digit gets a SHOW slot of REFRESH_DIV cycles preceded by a BLANK gap
// of BLANK_CYCLES cycles with every anode off (anti-ghosting). A pending
// value is only copied into the displayed value at frame wrap, so a frame
// never mixes old and new digits. All outputs are registered: the next-cycle
// output values are derived from the next FSM state and captured on the same
// edge as the state, so outputs line up with the state they describe.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  seg7_scan_if.slave  bus
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // True when every nibble from position k up to the top digit is zero,
  // i.e. digit k would be a leading zero.
  function automatic logic upper_zero(input logic [DW-1:0] d,
                                      input logic [IDX_W-1:0] k);
    logic z;
    z = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(k)) && (d[4*j +: 4] != 4'd0)) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             wrap;
  logic             commit;

  logic [DW-1:0]    disp_q;
  logic [DW-1:0]    pend_q;
  logic             pend_v_q;

  logic [NUM_DIGITS-1:0] an_p0,     an_p1;
  logic [3:0]            nibble_p0, nibble_p1;
  logic                  fs_p0,     fs_p1;
  logic                  ack_p0,    ack_p1;

  // FSM state, digit index and slot counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: slot length counting, digit advance and frame wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  assign commit = wrap && pend_v_q;

  // Pending/displayed value registers; a load coinciding with a commit
  // still commits the old pending value and re-arms with the new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      if (commit) begin
        disp_q <= pend_q;
      end
      if (bus.load) begin
        pend_q   <= bus.value;
        pend_v_q <= 1'b1;
      end else if (commit) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  // Next-cycle output values, derived from the state being entered.
  always_comb begin
    an_p0     = '1;
    nibble_p0 = nibble_p1;
    fs_p0     = 1'b0;
    ack_p0    = commit;
    if (state_d == ST_SHOW) begin
      nibble_p0 = disp_q[{idx_d, 2'b00} +: 4];
      if (!(bus.lz_en && (idx_d != '0) && upper_zero(disp_q, idx_d))) begin
        an_p0[idx_d] = 1'b0;
      end
      fs_p0 = (state_q == ST_BLANK) && (idx_d == '0);
    end
  end

  // ---- output register stage ----
  // Output registers: every pin changes only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_p1     <= '1;
      nibble_p1 <= 4'd0;
      fs_p1     <= 1'b0;
      ack_p1    <= 1'b0;
    end else begin
      an_p1     <= an_p0;
      nibble_p1 <= nibble_p0;
      fs_p1     <= fs_p0;
      ack_p1    <= ack_p0;
    end
  end

  assign bus.digit_an_n  = an_p1;
  assign bus.nibble      = nibble_p1;
  assign bus.frame_start = fs_p1;
  assign bus.load_ack    = ack_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 4-cycle SHOW, 2-cycle
// BLANK). The reference model derives slot/digit position purely from the
// cycle count since reset release and tracks the pending/displayed values
// as plain variables updated at frame boundaries.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BK    = 2;
  localparam int SLOT  = RD + BK;
  localparam int FRAME = ND * SLOT;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  seg7_scan_if #(.NUM_DIGITS(ND)) sig ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BK)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (sig)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  int          t;
  logic [15:0] m_disp, m_pend;
  logic        m_pv, m_ack, m_fs;
  logic [3:0]  m_nib, m_an;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_all();
    chk("an",    16'(sig.digit_an_n),  16'(m_an));
    chk("nib",   16'(sig.nibble),      16'(m_nib));
    chk("fs",    16'(sig.frame_start), 16'(m_fs));
    chk("ack",   16'(sig.load_ack),    16'(m_ack));
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic tick(input logic ld, input logic [15:0] v);
    logic lz;
    int   tn, sl, ix;
    sig.load  = ld;
    sig.value = v;
    lz = sig.lz_en;
    @(posedge clk);
    tn = t + 1;
    m_ack = 1'b0;
    if ((tn % FRAME == 0) && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
      m_ack  = 1'b1;
    end
    if (ld) begin
      m_pend = v;
      m_pv   = 1'b1;
    end
    sl   = tn % SLOT;
    ix   = (tn / SLOT) % ND;
    m_an = 4'hF;
    m_fs = 1'b0;
    if (sl >= BK) begin
      m_nib = 4'((m_disp >> (4 * ix)) & 16'hF);
      if (!(lz && ix != 0 && (m_disp >> (4 * ix)) == 16'd0)) m_an[ix] = 1'b0;
      m_fs = (ix == 0) && (sl == BK);
    end
    t = tn;
    #1;
    sig.load = 1'b0;
    if (sig.load_ack === 1'b1) ack_cnt++;
    chk_all();
  endtask

  task automatic goto(input int pos);
    int n;
    n = 0;
    while (((t % FRAME) != pos) && (n < 2 * FRAME)) begin
      tick(1'b0, 16'h0);
      n++;
    end
    chk("goto", 16'(t % FRAME), 16'(pos));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_an",  16'(sig.digit_an_n),  16'hF);
    chk("rst_nib", 16'(sig.nibble),      16'h0);
    chk("rst_fs",  16'(sig.frame_start), 16'h0);
    chk("rst_ack", 16'(sig.load_ack),    16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
    m_nib = 4'h0; m_an = 4'hF; m_fs = 1'b0; m_ack = 1'b0;
    #1;
    chk_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sig.load = 1'b0; sig.value = '0; sig.lz_en = 1'b0;
    t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
    m_nib = 4'h0; m_an = 4'hF; m_fs = 1'b0; m_ack = 1'b0;
    #2;
    apply_reset();

    // Scenario 1: free-running scan, no load.
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 16'h0);
      if (t == 2) begin
        chk("s1_an_t2", 16'(sig.digit_an_n), 16'hE);
        chk("s1_fs_t2", 16'(sig.frame_start), 16'h1);
      end
      if (t == 6)  chk("s1_an_t6",  16'(sig.digit_an_n), 16'hF);
      if (t == 8)  chk("s1_an_t8",  16'(sig.digit_an_n), 16'hD);
      if (t == 26) chk("s1_fs_t26", 16'(sig.frame_start), 16'h1);
    end

    // Scenario 2: mid-frame load, commit at wrap, sequence 4,3,2,1.
    goto(10);
    tick(1'b1, 16'h1234);
    goto(0);
    chk("s2_ack", 16'(sig.load_ack), 16'h1);
    goto(BK);              chk("s2_d0", 16'(sig.nibble), 16'h4);
    goto(SLOT + BK);       chk("s2_d1", 16'(sig.nibble), 16'h3);
    goto(2 * SLOT + BK);   chk("s2_d2", 16'(sig.nibble), 16'h2);
    goto(3 * SLOT + BK);   chk("s2_d3", 16'(sig.nibble), 16'h1);

    // Scenario 3: two loads before wrap, last wins, leading zeros blanked.
    sig.lz_en = 1'b1;
    goto(5);
    ack_cnt = 0;
    tick(1'b1, 16'h00A5);
    tick(1'b0, 16'h0);
    tick(1'b1, 16'h0007);
    goto(0);
    repeat (FRAME) tick(1'b0, 16'h0);
    chk("s3_ackcnt", 16'(ack_cnt), 16'h1);
    goto(BK);              chk("s3_an0",  16'(sig.digit_an_n), 16'hE);
                           chk("s3_nib0", 16'(sig.nibble),     16'h7);
    goto(SLOT + BK);       chk("s3_an1",  16'(sig.digit_an_n), 16'hF);
    goto(SLOT + BK + 3);   chk("s3_an1e", 16'(sig.digit_an_n), 16'hF);
    goto(3 * SLOT + BK);   chk("s3_an3",  16'(sig.digit_an_n), 16'hF);

    // Scenario 4: load on the exact commit edge.
    sig.lz_en = 1'b0;
    goto(3);
    tick(1'b1, 16'h1111);
    goto(FRAME - 1);
    ack_cnt = 0;
    tick(1'b1, 16'hBEEF);
    chk("s4_ack1", 16'(sig.load_ack), 16'h1);
    goto(BK);              chk("s4_old", 16'(sig.nibble), 16'h1);
    goto(0);               chk("s4_ack2", 16'(sig.load_ack), 16'h1);
    goto(BK);              chk("s4_d0", 16'(sig.nibble), 16'hF);
    goto(SLOT + BK);       chk("s4_d1", 16'(sig.nibble), 16'hE);
    chk("s4_ackcnt", 16'(ack_cnt), 16'h2);

    // Scenario 5: reset during digit-2 SHOW with a pending load.
    goto(2 * SLOT + BK + 1);
    tick(1'b1, 16'h5678);
    apply_reset();
    ack_cnt = 0;
    repeat (FRAME + 6) tick(1'b0, 16'h0);
    chk("s5_ackcnt", 16'(ack_cnt), 16'h0);
    goto(BK);              chk("s5_d0", 16'(sig.nibble), 16'h0);
    goto(2 * SLOT + BK);   chk("s5_d2", 16'(sig.nibble), 16'h0);

    // Scenario 6: all-zero display with suppression, then suppression off.
    sig.lz_en = 1'b1;
    goto(SLOT + BK);       chk("s6_an1z", 16'(sig.digit_an_n), 16'hF);
    goto(BK);              chk("s6_an0z", 16'(sig.digit_an_n), 16'hE);
                           chk("s6_nib0", 16'(sig.nibble),     16'h0);
    sig.lz_en = 1'b0;
    goto(SLOT + BK);       chk("s6_an1",  16'(sig.digit_an_n), 16'hD);
    goto(2 * SLOT + BK);   chk("s6_an2",  16'(sig.digit_an_n), 16'hB);
    goto(3 * SLOT + BK);   chk("s6_an3",  16'(sig.digit_an_n), 16'h7);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        ld;
      logic [15:0] v;
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      if ($urandom_range(0, 15) == 0) sig.lz_en = ~sig.lz_en;
      tick(ld, v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
